psram_access_arbiter: RTL and testbench

Two-requester arbiter that shares the single PSRAM controller command port between the frame uploader (camera → PSRAM writes) and the display frame reader (PSRAM → LCD reads). It grants whole burst transactions using the same rq/ack handshake the uploader already drives, with round-robin fairness. It routes the granted requester's command, address and data to the memory controller, and includes a hold-time watchdog so a stuck requester cannot lock the memory out.

---
 rtl/psram_access_arbiter_if.sv | 39 +++
 rtl/psram_access_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_psram_access_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/psram_access_arbiter_if.sv
// Requester and PSRAM-controller signal bundle around the access arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding system.
interface psram_access_arbiter_if #(
  parameter int ADDR_W = 21
) ();
  logic              wr_rq;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_cmd_en;
  logic [31:0]       wr_data;
  logic              rd_rq;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_cmd_en;
  logic [31:0]       rd_data;
  logic              rd_data_valid;
  logic              mem_cmd;
  logic              mem_cmd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  logic [31:0]       mem_rd_data;
  logic              mem_rd_data_valid;

  modport slave (
    input  wr_rq, wr_addr, wr_cmd_en, wr_data,
    input  rd_rq, rd_addr, rd_cmd_en,
    input  mem_rd_data, mem_rd_data_valid,
    output wr_ack, rd_ack, rd_data, rd_data_valid,
    output mem_cmd, mem_cmd_en, mem_addr, mem_wr_data
  );

  modport master (
    output wr_rq, wr_addr, wr_cmd_en, wr_data,
    output rd_rq, rd_addr, rd_cmd_en,
    output mem_rd_data, mem_rd_data_valid,
    input  wr_ack, rd_ack, rd_data, rd_data_valid,
    input  mem_cmd, mem_cmd_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/psram_access_arbiter.sv
// Round-robin burst arbiter sharing one PSRAM command port between the frame writer and the
// display reader. It includes a hold watchdog that masks a requester stuck on its grant.
module psram_access_arbiter #(
  parameter int TCMD     = 19,
  parameter int MAX_HOLD = 63,
  parameter int ADDR_W   = 21
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_init_done_i,
  psram_access_arbiter_if.slave bus,
  output logic grant_wr_o,
  output logic grant_rd_o,
  output logic timeout_err_o
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [5:0]        TCMD_C     = 6'(TCMD);
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE_C = HOLD_W'(1);

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    IDLE      = 3'd1,
    GRANT_WR  = 3'd2,
    GRANT_RD  = 3'd3,
    RELEASE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              wr_mask_q, wr_mask_d;
  logic              rd_mask_q, rd_mask_d;
  logic [5:0]        tcmd_cnt_q, tcmd_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              timeout_q, timeout_d;
  logic              mem_cmd_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              own_rq_s;
  logic              own_cmd_en_s;
  logic              mem_cmd_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0]       mem_wr_data_s;
  logic              wr_elig_s;
  logic              rd_elig_s;

  assign wr_elig_s = bus.wr_rq & ~wr_mask_q;
  assign rd_elig_s = bus.rd_rq & ~rd_mask_q;

  // Command mux driven straight from the registered owner, so forwarding adds no latency.
  always_comb begin
    own_rq_s      = 1'b0;
    own_cmd_en_s  = 1'b0;
    mem_cmd_s     = mem_cmd_q;
    mem_addr_s    = mem_addr_q;
    mem_wr_data_s = 32'h0000_0000;
    case (state_q)
      GRANT_WR: begin
        own_rq_s      = bus.wr_rq;
        own_cmd_en_s  = bus.wr_cmd_en;
        mem_cmd_s     = 1'b1;
        mem_addr_s    = bus.wr_addr;
        mem_wr_data_s = bus.wr_data;
      end
      GRANT_RD: begin
        own_rq_s      = bus.rd_rq;
        own_cmd_en_s  = bus.rd_cmd_en;
        mem_cmd_s     = 1'b0;
        mem_addr_s    = bus.rd_addr;
        mem_wr_data_s = bus.wr_data;
      end
      default: begin
        own_rq_s     = 1'b0;
        own_cmd_en_s = 1'b0;
      end
    endcase
  end

  // Arbitration, burst-time and watchdog next-state logic.
  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    wr_mask_d  = wr_mask_q & bus.wr_rq;
    rd_mask_d  = rd_mask_q & bus.rd_rq;
    tcmd_cnt_d = tcmd_cnt_q;
    hold_cnt_d = hold_cnt_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      INIT_WAIT: begin
        if (mem_init_done_i) begin
          state_d = IDLE;
        end else begin
          state_d = INIT_WAIT;
        end
      end
      IDLE: begin
        // On a tie the side that did not own the port last time wins.
        if (wr_elig_s && (!rd_elig_s || !last_wr_q)) begin
          state_d    = GRANT_WR;
          last_wr_d  = 1'b1;
          wr_ack_d   = 1'b1;
          tcmd_cnt_d = 6'd0;
          hold_cnt_d = HOLD_ONE_C;
        end else if (rd_elig_s) begin
          state_d    = GRANT_RD;
          last_wr_d  = 1'b0;
          rd_ack_d   = 1'b1;
          tcmd_cnt_d = 6'd0;
          hold_cnt_d = HOLD_ONE_C;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_WR, GRANT_RD: begin
        if (own_cmd_en_s) begin
          tcmd_cnt_d = 6'd0;
        end else if (tcmd_cnt_q < TCMD_C) begin
          tcmd_cnt_d = tcmd_cnt_q + 6'd1;
        end else begin
          tcmd_cnt_d = tcmd_cnt_q;
        end
        if (hold_cnt_q < MAX_HOLD_C) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE_C;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
        if (!own_rq_s && (tcmd_cnt_q >= TCMD_C)) begin
          state_d = RELEASE;
        end else if (own_rq_s && (hold_cnt_q >= MAX_HOLD_C)) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
          if (state_q == GRANT_WR) begin
            wr_mask_d = 1'b1;
          end else begin
            rd_mask_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT_WAIT;
      end
    endcase
  end

  // State, counters, masks and registered pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT_WAIT;
      last_wr_q  <= 1'b0;
      wr_mask_q  <= 1'b0;
      rd_mask_q  <= 1'b0;
      tcmd_cnt_q <= 6'd0;
      hold_cnt_q <= '0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      timeout_q  <= 1'b0;
      mem_cmd_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      wr_mask_q  <= wr_mask_d;
      rd_mask_q  <= rd_mask_d;
      tcmd_cnt_q <= tcmd_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      timeout_q  <= timeout_d;
      mem_cmd_q  <= mem_cmd_s;
      mem_addr_q <= mem_addr_s;
    end
  end

  assign bus.wr_ack        = wr_ack_q;
  assign bus.rd_ack        = rd_ack_q;
  assign bus.mem_cmd       = mem_cmd_s;
  assign bus.mem_cmd_en    = own_cmd_en_s;
  assign bus.mem_addr      = mem_addr_s;
  assign bus.mem_wr_data   = mem_wr_data_s;
  assign bus.rd_data       = bus.mem_rd_data;
  assign bus.rd_data_valid = bus.mem_rd_data_valid & (state_q == GRANT_RD);
  assign grant_wr_o        = (state_q == GRANT_WR);
  assign grant_rd_o        = (state_q == GRANT_RD);
  assign timeout_err_o     = timeout_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed bench for psram_access_arbiter: init gating, uploader bursts, round-robin ties,
// the read data path, the hold watchdog with masking, and asynchronous reset mid-grant.
module tb_psram_access_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic init_done;
  logic grant_wr, grant_rd, timeout_err;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  psram_access_arbiter_if #(.ADDR_W(21)) ifc ();

  psram_access_arbiter #(.TCMD(19), .MAX_HOLD(63), .ADDR_W(21)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_init_done_i (init_done),
    .bus             (ifc.slave),
    .grant_wr_o      (grant_wr),
    .grant_rd_o      (grant_rd),
    .timeout_err_o   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an ack; who = 1 writer, 0 reader, -1 none.
  task automatic grab(input string tag, input int exp_who, input int exp_lat, output int who);
    int lat;
    who = -1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (ifc.wr_ack) begin
        who = 1; lat = i; break;
      end else if (ifc.rd_ack) begin
        who = 0; lat = i; break;
      end
    end
    chk({tag, "_who"}, 64'(who), 64'(exp_who));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_grant"}, {62'h0, grant_wr, grant_rd}, (exp_who == 1) ? 64'h2 : 64'h1);
  endtask

  // One burst by the owner 'who': cmd_en one cycle after ack, rq dropped 19 cycles later.
  task automatic txn_body(input string tag, input int who, input bit reraise);
    logic [20:0] a;
    logic [31:0] wd;
    int n;
    a  = (who == 1) ? 21'h0ABCD : 21'h1F00F;
    wd = 32'h5A5A_0000 ^ {11'h000, a};
    cyc();
    chk({tag, "_ack_pulse"}, {62'h0, ifc.wr_ack, ifc.rd_ack}, 64'h0);
    ifc.wr_data = wd;
    if (who == 1) begin
      ifc.wr_addr = a; ifc.wr_cmd_en = 1'b1;
    end else begin
      ifc.rd_addr = a; ifc.rd_cmd_en = 1'b1;
    end
    #1;
    chk({tag, "_cmd_en"}, 64'(ifc.mem_cmd_en), 64'h1);
    chk({tag, "_cmd"}, 64'(ifc.mem_cmd), (who == 1) ? 64'h1 : 64'h0);
    chk({tag, "_addr"}, 64'(ifc.mem_addr), 64'(a));
    chk({tag, "_wdata"}, 64'(ifc.mem_wr_data), 64'(wd));
    cyc();
    ifc.wr_cmd_en = (who == 1) ? 1'b0 : 1'b1;
    ifc.rd_cmd_en = (who == 1) ? 1'b1 : 1'b0;
    #1;
    chk({tag, "_loser_drop"}, 64'(ifc.mem_cmd_en), 64'h0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      ifc.wr_cmd_en = 1'b0;
      ifc.rd_cmd_en = 1'b0;
      ifc.mem_rd_data_valid = 1'b1;
      ifc.mem_rd_data = 32'hA5A5_0000 + 32'(k);
      #1;
      chk({tag, "_rvalid"}, 64'(ifc.rd_data_valid), (who == 0) ? 64'h1 : 64'h0);
      if (who == 0) chk({tag, "_rdata"}, 64'(ifc.rd_data), 64'hA5A5_0000 + 64'(k));
    end
    cyc();
    ifc.mem_rd_data_valid = 1'b0;
    repeat (9) cyc();
    if (who == 1) ifc.wr_rq = 1'b0; else ifc.rd_rq = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n++;
      if (!(grant_wr || grant_rd)) break;
    end
    chk({tag, "_release_cycles"}, 64'(n), 64'h2);
    chk({tag, "_rel_cmd_en"}, 64'(ifc.mem_cmd_en), 64'h0);
    chk({tag, "_rel_addr_hold"}, 64'(ifc.mem_addr), 64'(a));
    chk({tag, "_rel_cmd_hold"}, 64'(ifc.mem_cmd), (who == 1) ? 64'h1 : 64'h0);
    if (reraise) begin
      if (who == 1) ifc.wr_rq = 1'b1; else ifc.rd_rq = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL tb_time_limit: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int who, n;
    reset_n = 1'b0;
    init_done = 1'b0;
    ifc.wr_rq = 1'b1; ifc.wr_addr = '0; ifc.wr_cmd_en = 1'b0; ifc.wr_data = '0;
    ifc.rd_rq = 1'b0; ifc.rd_addr = '0; ifc.rd_cmd_en = 1'b0;
    ifc.mem_rd_data = '0; ifc.mem_rd_data_valid = 1'b0;

    repeat (3) cyc();
    chk("reset_outputs", {57'h0, grant_wr, grant_rd, ifc.wr_ack, ifc.rd_ack,
                          ifc.mem_cmd_en, ifc.mem_cmd, timeout_err}, 64'h0);
    chk("reset_addr", 64'(ifc.mem_addr), 64'h0);
    reset_n = 1'b1;

    // Requests are ignored until calibration completes.
    n = 0;
    repeat (10) begin
      cyc();
      if (ifc.wr_ack || ifc.rd_ack || grant_wr || grant_rd) n++;
    end
    chk("init_wait_block", 64'(n), 64'h0);
    init_done = 1'b1;
    grab("up", 1, 2, who);
    txn_body("up", 1, 1'b0);

    ifc.rd_rq = 1'b1;
    grab("rd", 0, 2, who);
    txn_body("rd", 0, 1'b0);

    // Both raised together: reader owned last, so the writer goes first.
    ifc.wr_rq = 1'b1;
    ifc.rd_rq = 1'b1;
    grab("tie0", 1, 2, who);
    txn_body("tie0", 1, 1'b1);
    grab("tie1", 0, 2, who);
    txn_body("tie1", 0, 1'b1);
    grab("tie2", 1, 2, who);
    txn_body("tie2", 1, 1'b1);
    grab("tie3", 0, 2, who);
    txn_body("tie3", 0, 1'b0);

    // Writer never drops rq: 63 grant cycles, then the watchdog releases it.
    grab("wd", 1, 2, who);
    cyc();
    ifc.wr_cmd_en = 1'b1;
    ifc.wr_addr = 21'h00777;
    cyc();
    ifc.wr_cmd_en = 1'b0;
    ifc.rd_rq = 1'b1;
    n = 3;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!grant_wr) break;
      n++;
    end
    chk("wd_grant_cycles", 64'(n), 64'd63);
    chk("wd_timeout_pulse", 64'(timeout_err), 64'h1);
    chk("wd_release_cmd_en", 64'(ifc.mem_cmd_en), 64'h0);
    cyc();
    chk("wd_timeout_one_cycle", 64'(timeout_err), 64'h0);
    grab("wd_rd", 0, 1, who);
    txn_body("wd_rd", 0, 1'b0);
    n = 0;
    repeat (6) begin
      cyc();
      if (ifc.wr_ack || grant_wr) n++;
    end
    chk("wd_masked", 64'(n), 64'h0);
    ifc.wr_rq = 1'b0;
    cyc();
    ifc.wr_rq = 1'b1;
    grab("wd_regrant", 1, 1, who);
    txn_body("wd_regrant", 1, 1'b0);

    // Asynchronous reset in the middle of a read grant.
    ifc.rd_rq = 1'b1;
    grab("rst_rd", 0, 2, who);
    cyc();
    ifc.rd_cmd_en = 1'b1;
    ifc.rd_addr = 21'h15555;
    ifc.mem_rd_data_valid = 1'b1;
    ifc.wr_rq = 1'b1;
    #1;
    chk("rst_pre_cmd_en", 64'(ifc.mem_cmd_en), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", {56'h0, grant_wr, grant_rd, ifc.wr_ack, ifc.rd_ack,
                              ifc.mem_cmd_en, ifc.mem_cmd, timeout_err, ifc.rd_data_valid}, 64'h0);
    chk("rst_async_addr", 64'(ifc.mem_addr), 64'h0);
    ifc.rd_cmd_en = 1'b0;
    ifc.mem_rd_data_valid = 1'b0;
    repeat (2) cyc();
    #2;
    reset_n = 1'b1;
    grab("rst_tie", 1, 2, who);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
